// File: rtl/typing_countdown_timer_pkg.sv
// typing_timer_pkg: shared state encoding and BCD helpers for the typing countdown timer
package typing_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  function automatic logic [7:0] bcd_dec(input logic [7:0] c);
    return (c == 8'h00) ? 8'h00 :
           (c[3:0] == 4'd0) ? {c[7:4] - 4'd1, 4'd9} : {c[7:4], c[3:0] - 4'd1};
  endfunction
  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction
endpackage

// File: rtl/typing_countdown_timer_if.sv
// typing_countdown_timer_if: control pulses in, display/status signals out
interface typing_countdown_timer_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] digit_one;
  logic [3:0] digit_two;
  logic       one_en;
  logic       two_en;
  logic       running;
  logic       expired;
  logic       expire_pulse;
  modport master (
    output start, pause, clear,
    input  digit_one, digit_two, one_en, two_en, running, expired, expire_pulse
  );
  modport slave (
    input  start, pause, clear,
    output digit_one, digit_two, one_en, two_en, running, expired, expire_pulse
  );
endinterface

// File: rtl/typing_countdown_timer_tick_prescaler.sv
// tick_prescaler: counts fast_clk cycles and strobes once per second while enabled
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic                             fast_clk,
  input  logic                             rst_n,
  input  logic                             i_en,
  input  logic                             i_clr,
  output logic [$clog2(TICKS_PER_SEC)-1:0] o_cnt,
  output logic                             o_tick
);
  localparam int W = $clog2(TICKS_PER_SEC);
  logic [W-1:0] r_cnt;
  assign o_cnt  = r_cnt;
  assign o_tick = i_en && (r_cnt == W'(TICKS_PER_SEC - 1));
  // wrap at the terminal count; clear wins over enable
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/typing_countdown_timer.sv
// typing_countdown_timer: two-digit BCD seconds countdown feeding the seven-segment driver
module typing_countdown_timer
  import typing_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int START_SECS    = 60,
  parameter int WARN_SECS     = 10
) (
  input logic                     fast_clk,
  input logic                     rst_n,
  typing_countdown_timer_if.slave bus
);
  localparam logic [7:0] PRESET = to_bcd(START_SECS);
  localparam int W = $clog2(TICKS_PER_SEC);
  state_t       r_state;
  logic [7:0]   r_count;
  logic         r_pulse;
  logic [W-1:0] w_presc;
  logic         w_tick;
  logic         w_en;
  logic         w_clr;
  logic [6:0]   w_secs;
  logic         w_blink;
  assign w_en  = (r_state == RUN) || (r_state == EXPIRED);
  assign w_clr = bus.clear || (r_state == IDLE);
  tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .fast_clk (fast_clk),
    .rst_n    (rst_n),
    .i_en     (w_en),
    .i_clr    (w_clr),
    .o_cnt    (w_presc),
    .o_tick   (w_tick)
  );
  // state, count and expiry pulse; clear > pause > start, expiry beats a same-cycle pause
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= PRESET;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_count <= PRESET;
      end else begin
        case (r_state)
          IDLE: begin
            r_count <= PRESET;
            if (bus.start) r_state <= RUN;
          end
          RUN: begin
            if (w_tick) r_count <= bcd_dec(r_count);
            if (w_tick && r_count == 8'h01) begin
              r_state <= EXPIRED;
              r_pulse <= 1'b1;
            end else if (bus.pause) r_state <= PAUSED;
          end
          PAUSED: if (bus.start) r_state <= RUN;
          default: r_count <= 8'h00;
        endcase
      end
    end
  end
  assign w_secs  = 7'(r_count[7:4]) * 7'd10 + 7'(r_count[3:0]);
  assign w_blink = (WARN_SECS != 0) && (w_presc < W'(TICKS_PER_SEC / 2)) &&
                   ((r_state == RUN && w_secs <= 7'(WARN_SECS)) || r_state == EXPIRED);
  assign bus.digit_one    = r_count[7:4];
  assign bus.digit_two    = r_count[3:0];
  assign bus.one_en       = (r_count[7:4] != 4'd0) && !w_blink;
  assign bus.two_en       = !w_blink;
  assign bus.running      = (r_state == RUN);
  assign bus.expired      = (r_state == EXPIRED);
  assign bus.expire_pulse = r_pulse;
endmodule

// File: doc/typing_countdown_timer.md
# typing_countdown_timer

Two-digit BCD countdown timer that bounds a typing-test round and feeds the two-digit seven-segment driver `ssd_display` directly upstream. It counts seconds down from a preset, supports start, pause, resume and clear, and raises an expiry pulse for the game FSM. It drives the driver's `digit_one`/`digit_two`/`one_en`/`two_en` inputs, using the enables for leading-zero suppression and low-time blinking. A disabled digit renders as "-" downstream.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: `fast_clk` cycles per second; must be ≥ 2.
- `START_SECS`, default 60: preset in seconds; legal range 1..99.
- `WARN_SECS`, default 10: blinking is active while remaining ≤ `WARN_SECS` in RUN; 0 disables blinking.
- `fast_clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin a round, or resume from pause.
- `pause`  in  1  one-cycle pulse: freeze the countdown.
- `clear`  in  1  one-cycle pulse: abort the round and reload the preset.
- `digit_one`  out  4  tens digit, BCD.
- `digit_two`  out  4  ones digit, BCD.
- `one_en`  out  1  tens digit enable.
- `two_en`  out  1  ones digit enable.
- `running`  out  1  high in RUN.
- `expired`  out  1  high in EXPIRED.
- `expire_pulse`  out  1  one-cycle pulse on entry to EXPIRED.

## Operation
- State registers:
  - FSM state.
  - BCD count {tens, ones}.
  - Prescaler, 0..`TICKS_PER_SEC`-1, width $clog2(`TICKS_PER_SEC`).
- States:
  - IDLE: count = preset; prescaler held at 0.
    - `start` → RUN.
  - RUN: prescaler increments each cycle.
    - At `TICKS_PER_SEC`-1 the prescaler wraps to 0 and the count decrements.
    - A decrement from 01 to 00 → EXPIRED.
    - `pause` → PAUSED.
  - PAUSED: count and prescaler are held.
    - `start` → RUN; the prescaler resumes from its held value.
  - EXPIRED: count = 00; prescaler free-runs.
    - `start` and `pause` are ignored.
- `clear` in any state → IDLE, reloading the preset and setting prescaler to 0.
- Priority: `clear` > `pause` > `start`.
  - `start` in RUN is ignored.
  - `pause` in IDLE, PAUSED and EXPIRED is ignored.
- If a tick and `pause` occur in the same cycle, the decrement is applied and the state becomes PAUSED.
- BCD decrement:
  - ones 0 → 9 with tens − 1.
  - Otherwise ones − 1.
  - Count never goes below 00.
- `digit_one` = tens and `digit_two` = ones, in all states.
- Enables:
  - Blink phase is active when prescaler < `TICKS_PER_SEC`/2 and either (RUN and count ≤ `WARN_SECS`) or EXPIRED.
  - `two_en` = !blink phase.
  - `one_en` = (tens ≠ 0) && !blink phase.

## Timing
- Reset values:
  - state IDLE; count = `START_SECS` as BCD; prescaler 0.
  - `running`, `expired` and `expire_pulse` are 0.
  - `one_en` = (preset tens ≠ 0); `two_en` = 1.
- All outputs are combinational decodes of registers, with no input-to-output combinational path.
- Input latency: a `start`/`pause`/`clear` pulse sampled at edge t is reflected in outputs after edge t.
- First decrement is visible `TICKS_PER_SEC` cycles after RUN is entered.
- An uninterrupted round lasts exactly `START_SECS`×`TICKS_PER_SEC` cycles from RUN entry to `expired` = 1.
- `expire_pulse` is high for exactly one cycle, coincident with the first cycle of `expired`.
- Asserting `rst_n` low mid-round immediately forces all reset values.

## Structure
- Shared package `typing_timer_pkg`:
  - state enum (IDLE, RUN, PAUSED, EXPIRED).
  - `bcd_dec` function.
  - binary-to-BCD preset conversion constant function.
- Sub-module `tick_prescaler`:
  - inputs: enable and synchronous clear.
  - outputs: count value and terminal-tick strobe.
  - parameter: `TICKS_PER_SEC`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4, `START_SECS`=12, `WARN_SECS`=3.

- Reset → digits 1/2, `one_en`=`two_en`=1, `running`=0, `expired`=0.
- `start` and no further input:
  - count sequence 12, 11, 10, 09, …, 00, with 4 cycles per step.
  - 10→09 wraps correctly and `one_en` drops to 0 at 09.
  - `expire_pulse` fires once, exactly 48 cycles after RUN entry.
- `pause` when count=07 and prescaler=2:
  - 20 idle cycles leave 07 and the prescaler unchanged.
  - `start` → decrement to 06 after 2 more cycles.
- `clear`+`start` in the same cycle at count 05 → IDLE with count 12 and `running`=0.
- Blink behaviour:
  - At count 03, `two_en`=0 for prescaler 0–1 and 1 for prescaler 2–3.
  - In EXPIRED the same 4-cycle blink applies to the 00 display.
  - `start` in EXPIRED is ignored.
- `rst_n` low mid-round at count 08 → immediate IDLE/12; counting restarts only on the next `start`.
